// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one combinational ALU.
// Each operation is accepted over a valid/ready handshake, held on the ALU
// for ALU_LAT cycles, and its result is returned to the requester that
// issued it over a valid/ready response channel.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins
// every tie). Without it, ties are resolved round-robin.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 5,
  parameter int ALU_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [WIDTH-1:0]    rsp0_data,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [WIDTH-1:0]    rsp1_data,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                busy
);

  // ALU_LAT is at most 15, so the counter never has to hold more than 14.
  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;       // requester that would win this cycle
  logic             last_grant;  // requester that won the previous arbitration
  logic             owner;       // requester whose operation is in flight
  logic             accept;      // handshake completes on the coming edge
  logic             owner_ready; // owner takes its result on the coming edge
  logic [CNT_W-1:0] cnt;

  // Pick the winner: a lone requester always wins; on a tie the policy decides.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state logic and handshake/status outputs for the sequencing FSM.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    busy        = (state != IDLE);
    accept      = 1'b0;
    owner_ready = owner ? rsp1_ready : rsp0_ready;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, arbitration history and the ALU latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else if (accept) begin
      alu_op     <= grant ? req1_op : req0_op;
      alu_a      <= grant ? req1_a  : req0_a;
      alu_b      <= grant ? req1_b  : req0_b;
      owner      <= grant;
      last_grant <= grant;
      cnt        <= CNT_LOAD;
    end else if ((state == EXEC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Sample the ALU result into the owner's response register at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else if ((state == EXEC) && (cnt == '0)) begin
      if (owner) begin
        rsp1_data <= alu_out;
      end else begin
        rsp0_data <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model. A behavioural ALU model sits on the
// DUT's alu_* ports. A second instance with ALU_LAT=3 covers reset during
// an operation. Grant expectations follow ALU_ARB_FIXED_PRIO_EN if defined.
module tb_alu_arbiter;
  localparam int W    = 32;
  localparam int OW   = 5;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  localparam logic [OW-1:0] OP_ADD = 5'b00001;
  localparam logic [OW-1:0] OP_SUB = 5'b10001;
  localparam logic [OW-1:0] OP_XOR = 5'b01001;
  localparam logic [OW-1:0] OP_AND = 5'b01111;
  localparam logic [OW-1:0] OP_SLT = 5'b00101;
  localparam logic [OW-1:0] OP_SLL = 5'b00011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [W-1:0] rsp0_data, rsp1_data;

  logic rst3, t3_req0_valid, t3_req0_ready, t3_req1_ready;
  logic [OW-1:0] t3_req0_op, t3_alu_op;
  logic [W-1:0] t3_req0_a, t3_req0_b, t3_alu_a, t3_alu_b, t3_alu_out;
  logic t3_rsp0_valid, t3_rsp0_ready, t3_rsp1_valid, t3_busy;
  logic [W-1:0] t3_rsp0_data, t3_rsp1_data;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural ALU: what the shared alu computes for each opcode.
  function automatic logic [W-1:0] alu_model(input logic [OW-1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      default: return (a | b) ^ {27'd0, op};
    endcase
  endfunction

  always_comb alu_out    = alu_model(alu_op, alu_a, alu_b);
  always_comb t3_alu_out = alu_model(t3_alu_op, t3_alu_a, t3_alu_b);

  alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .busy(busy)
  );

  alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready), .req0_op(t3_req0_op),
    .req0_a(t3_req0_a), .req0_b(t3_req0_b),
    .req1_valid(1'b0), .req1_ready(t3_req1_ready), .req1_op(5'd0),
    .req1_a(32'd0), .req1_b(32'd0),
    .rsp0_valid(t3_rsp0_valid), .rsp0_ready(t3_rsp0_ready), .rsp0_data(t3_rsp0_data),
    .rsp1_valid(t3_rsp1_valid), .rsp1_ready(1'b1), .rsp1_data(t3_rsp1_data),
    .alu_op(t3_alu_op), .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_out(t3_alu_out),
    .busy(t3_busy)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] rand_op();
    logic [OW-1:0] ops [6];
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_SLT, OP_SLL};
    if ($urandom_range(0, 7) == 0) return OW'($urandom_range(0, 31));
    return ops[$urandom_range(0, 5)];
  endfunction

  // Tie-break rule of the arbiter, given who won last time.
  function automatic bit tie_winner(input bit last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return !last;
`endif
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp0_valid"}, rsp0_valid, 0);
    check({tag, "_rsp1_valid"}, rsp1_valid, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_rsp0_data"}, rsp0_data, 0);
    check({tag, "_rsp1_data"}, rsp1_data, 0);
    tick();
  endtask

  // Issue one operation from requester 'who' with both response readies high.
  task automatic run_op(input bit who, input logic [OW-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input string tag,
                        output int waited);
    bit got;
    int lat;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (!who) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) got = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
    check({tag, "_accept"}, got, 1);
    if (!got) begin
      tick();
      if (!who) req0_valid = 1'b0; else req1_valid = 1'b0;
      return;
    end
    check({tag, "_other_ready"}, who ? req0_ready : req1_ready, 0);
    check({tag, "_busy_idle"}, busy, 0);
    tick();
    if (!who) req0_valid = 1'b0; else req1_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who ? rsp1_valid : rsp0_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_data"}, who ? rsp1_data : rsp0_data, exp);
    check({tag, "_other_rsp"}, who ? rsp0_valid : rsp1_valid, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    bit got, seen;
    int lat;
    int ng;
    int grants[4];
    int exp_g[4];
    // reference model state
    bit m_idle, m_last, m_owner, acc0, acc1, win;
    int m_age;
    logic [W-1:0] m_res;
    logic [W-1:0] m_data[2];

    rst = 1'b1; rst3 = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    t3_req0_valid = 0; t3_req0_op = 0; t3_req0_a = 0; t3_req0_b = 0; t3_rsp0_ready = 1;
    tick();
    rst3 = 1'b0;

    // Reset state
    do_reset("rst");

    // Single ADD from req0
    run_op(1'b0, OP_ADD, 32'h5, 32'h3, 32'h8, "t1", waited);
    @(negedge clk);
    check("t1_idle_after", busy, 0);
    check("t1_rsp0_dropped", rsp0_valid, 0);
    tick();

    // Simultaneous requests after reset
    do_reset("t2rst");
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hFF00FF00; req1_b = 32'h0F0F0F0F;
    run_op(1'b0, OP_SUB, 32'd10, 32'd3, 32'h7, "t2_first", waited);
    run_op(1'b1, OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, "t2_second", waited);
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd1;
    run_op(1'b0, OP_ADD, 32'd20, 32'd22, 32'd42, "t2_third", waited);
    run_op(1'b1, OP_ADD, 32'd1, 32'd1, 32'd2, "t2_fourth", waited);

    // Backpressure on rsp0 while req1 waits
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'hF0F0F0F0; req0_b = 32'hFFFF0000;
    rsp0_ready = 1'b0;
    @(negedge clk);
    check("t3_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'h1; req1_b = 32'h2;
    @(negedge clk);
    check("t3_exec_req1_ready", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", rsp0_valid, 1);
      check("t3_hold_data", rsp0_data, 32'hF0F00000);
      check("t3_hold_req1_ready", req1_ready, 0);
      check("t3_hold_busy", busy, 1);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    run_op(1'b1, OP_XOR, 32'h1, 32'h2, 32'h3, "t3_req1", waited);
    check("t3_req1_wait", waited, 0);

    // Signed compare and shift through req1
    run_op(1'b1, OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, "t4_slt", waited);
    run_op(1'b1, OP_SLL, 32'h1, 32'h4, 32'h10, "t4_sll", waited);

    // ALU_LAT=3 instance: reset on the second EXEC cycle
    t3_req0_valid = 1'b1; t3_req0_op = OP_ADD; t3_req0_a = 32'd2; t3_req0_b = 32'd2;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (t3_req0_ready) got = 1'b1; else tick();
    end
    check("t5_accept", got, 1);
    tick();
    t3_req0_valid = 1'b0;
    @(negedge clk);
    check("t5_exec1_busy", t3_busy, 1);
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    @(negedge clk);
    check("t5_busy", t3_busy, 0);
    check("t5_rsp0_valid", t3_rsp0_valid, 0);
    check("t5_alu_op", t3_alu_op, 0);
    check("t5_alu_a", t3_alu_a, 0);
    check("t5_alu_b", t3_alu_b, 0);
    check("t5_rsp0_data", t3_rsp0_data, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      seen = seen | t3_rsp0_valid | t3_rsp1_valid;
    end
    check("t5_no_stale_rsp", seen, 0);
    tick();
    t3_req0_valid = 1'b1; t3_req0_op = OP_SUB; t3_req0_a = 32'd9; t3_req0_b = 32'd4;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (t3_req0_ready) got = 1'b1; else tick();
    end
    check("t5_accept2", got, 1);
    tick();
    t3_req0_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (t3_rsp0_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check("t5_rsp_seen", got, 1);
    check("t5_latency", lat, LAT3);
    check("t5_data", t3_rsp0_data, 32'd5);
    tick();
    @(negedge clk);
    check("t5_idle_after", t3_busy, 0);
    tick();

    // Continuous contention: four grants
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset("t6rst");
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = $urandom; req1_b = $urandom;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      check("t6_single_ready", req0_ready & req1_ready, 0);
      got = 1'b0;
      if (req0_ready) begin grants[ng] = 0; ng++; got = 1'b1; end
      else if (req1_ready) begin grants[ng] = 1; ng++; got = 1'b1; end
      tick();
      if (got) begin
        req0_a = $urandom;
        req1_a = $urandom;
      end
    end
    check("t6_grant_count", ng, 4);
    for (int k = 0; k < ng; k++) check($sformatf("t6_grant%0d", k), grants[k], exp_g[k]);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("t6_drained", busy, 0);
    tick();

    // Randomized run against the transaction model
    do_reset("rnd_rst");
    m_idle = 1'b1; m_last = 1'b1; m_owner = 1'b0; m_age = 0; m_res = '0;
    m_data[0] = '0; m_data[1] = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      acc0 = 1'b0; acc1 = 1'b0;
      if (m_idle) begin
        if (req0_valid && req1_valid) win = tie_winner(m_last);
        else win = req1_valid;
        acc0 = req0_valid && !win;
        acc1 = req1_valid && win;
      end
      check("rnd_req0_ready", req0_ready, acc0);
      check("rnd_req1_ready", req1_ready, acc1);
      check("rnd_busy", busy, !m_idle);
      check("rnd_rsp0_valid", rsp0_valid, !m_idle && m_age >= LAT && !m_owner);
      check("rnd_rsp1_valid", rsp1_valid, !m_idle && m_age >= LAT && m_owner);
      check("rnd_rsp0_data", rsp0_data, m_data[0]);
      check("rnd_rsp1_data", rsp1_data, m_data[1]);
      // advance the model across the coming edge
      if (acc0 || acc1) begin
        m_idle = 1'b0; m_owner = acc1; m_last = acc1; m_age = 0;
        m_res = acc1 ? alu_model(req1_op, req1_a, req1_b) : alu_model(req0_op, req0_a, req0_b);
      end else if (!m_idle) begin
        if (m_age >= LAT) begin
          if (m_owner ? rsp1_ready : rsp0_ready) m_idle = 1'b1;
        end else begin
          m_age++;
          if (m_age == LAT) m_data[m_owner] = m_res;
        end
      end
      tick();
      if (acc0 || !req0_valid) begin
        req0_valid = acc0 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        req0_op = rand_op(); req0_a = $urandom; req0_b = $urandom;
      end
      if (acc1 || !req1_valid) begin
        req1_valid = acc1 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        req1_op = rand_op(); req1_a = $urandom; req1_b = $urandom;
      end
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("rnd_drained", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
